// File: rtl/clk_div_ctrl_pkg.sv
// Shared state encoding and constants for the clk_div_ctrl divided-clock bank.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } ch_state_t;

   localparam int MIN_DIV    = 2;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: period counter, OFF/RUN/PEND state and queued update.
// The align restart input exists only when CLK_DIV_CTRL_ALIGN_EN is defined.
module clk_div_ch
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef CLK_DIV_CTRL_ALIGN_EN
   input  logic             align_i,
`endif
   input  logic             req_i,
   input  logic             req_en_i,
   input  logic [CNT_W-1:0] req_div_i,
   output logic             div_clk_o,
   output logic             tick_o,
   output logic             busy_o
);

   ch_state_t        st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] pdiv_q, pdiv_d;
   logic             pen_q, pen_d;
   logic             div_clk_q, tick_q;
   logic             wrap, restart, apply;

   assign wrap = (cnt_q == n_q - CNT_W'(1));

`ifdef CLK_DIV_CTRL_ALIGN_EN
   assign restart = align_i && (st_q != OFF);
`else
   assign restart = 1'b0;
`endif

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      n_d    = n_q;
      pdiv_d = pdiv_q;
      pen_d  = pen_q;
      apply  = 1'b0;
      case (st_q)
         RUN, PEND: begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            apply = (st_q == PEND) && (wrap || restart);
            if ((st_q == RUN) && req_i) begin
               st_d   = PEND;
               pdiv_d = req_div_i;
               pen_d  = req_en_i;
            end
            if (restart) begin
               cnt_d = '0;
            end
         end
         default: begin
            if (req_i && req_en_i) begin
               st_d  = RUN;
               n_d   = req_div_i;
               cnt_d = '0;
            end
         end
      endcase
      // A queued update only lands on a period boundary (or an align restart).
      if (apply) begin
         st_d  = pen_q ? RUN : OFF;
         n_d   = pen_q ? pdiv_q : n_q;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q      <= OFF;
         cnt_q     <= '0;
         n_q       <= CNT_W'(MIN_DIV);
         pdiv_q    <= CNT_W'(MIN_DIV);
         pen_q     <= 1'b0;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         pdiv_q    <= pdiv_d;
         pen_q     <= pen_d;
         div_clk_q <= (st_d != OFF) && (cnt_d < (n_d >> 1));
         tick_q    <= (st_d != OFF) && (cnt_d == n_d - CNT_W'(1)) && !restart;
      end
   end

   assign div_clk_o = div_clk_q;
   assign tick_o    = tick_q;
   assign busy_o    = (st_q == PEND);

endmodule

// File: rtl/clk_div_ctrl.sv
// Bank of NUM_CH programmable clock dividers: request decode, cfg_ready/cfg_err, align fan-out.
// Optional phase-align input is present only when CLK_DIV_CTRL_ALIGN_EN is defined.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef CLK_DIV_CTRL_ALIGN_EN
   input  logic                      align,
`endif
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]          cfg_div,
   input  logic                      cfg_en,
   output logic                      cfg_err,
   output logic [NUM_CH-1:0]         div_clk,
   output logic [NUM_CH-1:0]         tick,
   output logic [NUM_CH-1:0]         busy
);

   logic              cfg_acc, div_bad;
   logic              cfg_err_q, cfg_err_d;
   logic [NUM_CH-1:0] req;

   // Out-of-range channel numbers are accepted and silently dropped.
   assign cfg_ready = (int'(cfg_ch) < NUM_CH) ? !busy[cfg_ch] : 1'b1;
   assign cfg_acc   = cfg_valid && cfg_ready;
   assign div_bad   = cfg_en && (cfg_div < CNT_W'(MIN_DIV));
   assign cfg_err_d = cfg_acc && div_bad;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign req[g] = cfg_acc && !div_bad && (int'(cfg_ch) == g);

      clk_div_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
`ifdef CLK_DIV_CTRL_ALIGN_EN
         .align_i   (align),
`endif
         .req_i     (req[g]),
         .req_en_i  (cfg_en),
         .req_div_i (cfg_div),
         .div_clk_o (div_clk[g]),
         .tick_o    (tick[g]),
         .busy_o    (busy[g])
      );
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; align steps build only with CLK_DIV_CTRL_ALIGN_EN.
module tb_clk_div_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      cfg_valid;
   logic                      cfg_ready;
   logic [$clog2(NUM_CH)-1:0] cfg_ch;
   logic [CNT_W-1:0]          cfg_div;
   logic                      cfg_en;
   logic                      cfg_err;
   logic [NUM_CH-1:0]         div_clk;
   logic [NUM_CH-1:0]         tick;
   logic [NUM_CH-1:0]         busy;
`ifdef CLK_DIV_CTRL_ALIGN_EN
   logic                      align;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef CLK_DIV_CTRL_ALIGN_EN
      .align     (align),
`endif
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .cfg_err   (cfg_err),
      .div_clk   (div_clk),
      .tick      (tick),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic req(input int ch, input int div, input logic en);
      cfg_valid = 1'b1;
      cfg_ch    = ch[1:0];
      cfg_div   = div[CNT_W-1:0];
      cfg_en    = en;
   endtask

   initial begin
      logic [15:0] dc, tk, bz, rd, dc1, tk1;
      logic [3:0]  oth;
      logic        found;

      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_en    = 1'b0;
`ifdef CLK_DIV_CTRL_ALIGN_EN
      align     = 1'b0;
`endif
      step();
      step();
      chk("rst_div_clk", 32'(div_clk), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cfg_err", 32'(cfg_err), 32'h0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);

      // ch0 at N=4: 2 high / 2 low, tick on the last cycle
      rst_n = 1'b1;
      req(0, 4, 1'b1);
      chk("ch0_ready", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      dc = '0; tk = '0; oth = '0;
      for (int i = 0; i < 8; i++) begin
         dc  = {dc[14:0], div_clk[0]};
         tk  = {tk[14:0], tick[0]};
         oth = oth | {1'b0, div_clk[3:1] | tick[3:1]} | busy;
         step();
      end
      chk("ch0_div4_clk", 32'(dc), 32'h00CC);
      chk("ch0_div4_tick", 32'(tk), 32'h0011);
      chk("others_idle", 32'(oth), 32'h0);

      // ch1 at N=5: 2 high / 3 low
      req(1, 5, 1'b1);
      step();
      cfg_valid = 1'b0;
      dc = '0; tk = '0;
      for (int i = 0; i < 10; i++) begin
         dc = {dc[14:0], div_clk[1]};
         tk = {tk[14:0], tick[1]};
         step();
      end
      chk("ch1_div5_clk", 32'(dc), 32'h0318);
      chk("ch1_div5_tick", 32'(tk), 32'h0021);

      // mid-period change of ch1 to N=2, accepted while cnt=1
      step();
      req(1, 2, 1'b1);
      chk("ch1_mid_ready", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      dc = '0; tk = '0; bz = '0; rd = '0;
      for (int i = 0; i < 7; i++) begin
         dc = {dc[14:0], div_clk[1]};
         tk = {tk[14:0], tick[1]};
         bz = {bz[14:0], busy[1]};
         rd = {rd[14:0], cfg_ready};
         step();
      end
      chk("ch1_pend_clk", 32'(dc), 32'h000A);
      chk("ch1_pend_tick", 32'(tk), 32'h0015);
      chk("ch1_pend_busy", 32'(bz), 32'h0070);
      chk("ch1_pend_ready", 32'(rd), 32'h000F);

      // illegal ratio on ch2
      req(2, 1, 1'b1);
      chk("ch2_ready", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      chk("ch2_err_pulse", 32'(cfg_err), 32'h1);
      chk("ch2_busy", 32'(busy), 32'h0);
      chk("ch2_div_clk", 32'(div_clk[2]), 32'h0);
      step();
      chk("ch2_err_once", 32'(cfg_err), 32'h0);
      chk("ch2_still_off", 32'(div_clk[2]), 32'h0);

      // stop request to an OFF channel with ratio 0 is legal and changes nothing
      req(3, 0, 1'b0);
      step();
      cfg_valid = 1'b0;
      chk("ch3_no_err", 32'(cfg_err), 32'h0);
      step();
      chk("ch3_off_clk", 32'(div_clk[3]), 32'h0);
      chk("ch3_off_busy", 32'(busy[3]), 32'h0);

      // stop ch0 with the request landing in its tick cycle
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (tick[0]) found = 1'b1;
         else step();
      end
      chk("ch0_tick_seen", 32'(found), 32'h1);
      req(0, 4, 1'b0);
      chk("ch0_stop_ready", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      dc = '0; tk = '0; bz = '0;
      for (int i = 0; i < 6; i++) begin
         dc = {dc[14:0], div_clk[0]};
         tk = {tk[14:0], tick[0]};
         bz = {bz[14:0], busy[0]};
         step();
      end
      chk("ch0_stop_clk", 32'(dc), 32'h0030);
      chk("ch0_stop_tick", 32'(tk), 32'h0004);
      chk("ch0_stop_busy", 32'(bz), 32'h003C);

      // reset with ch0/ch1 running and ch1 pending
      req(0, 3, 1'b1);
      step();
      req(1, 7, 1'b1);
      chk("ch1_pre_rst_ready", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      chk("pre_rst_busy", 32'(busy), 32'h2);
      rst_n = 1'b0;
      step();
      chk("mid_rst_div_clk", 32'(div_clk), 32'h0);
      chk("mid_rst_tick", 32'(tick), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_err", 32'(cfg_err), 32'h0);
      chk("mid_rst_ready", 32'(cfg_ready), 32'h1);
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_idle", 32'(div_clk | tick), 32'h0);

`ifdef CLK_DIV_CTRL_ALIGN_EN
      req(0, 4, 1'b1);
      step();
      req(1, 6, 1'b1);
      step();
      cfg_valid = 1'b0;
      step();
      step();
      align = 1'b1;
      step();
      align = 1'b0;
      chk("align_both_high", 32'(div_clk[1:0]), 32'h3);
      chk("align_no_tick", 32'(tick), 32'h0);
      dc = '0; tk = '0; dc1 = '0; tk1 = '0;
      for (int i = 0; i < 6; i++) begin
         dc  = {dc[14:0], div_clk[0]};
         tk  = {tk[14:0], tick[0]};
         dc1 = {dc1[14:0], div_clk[1]};
         tk1 = {tk1[14:0], tick[1]};
         step();
      end
      chk("align_ch0_clk", 32'(dc), 32'h0033);
      chk("align_ch0_tick", 32'(tk), 32'h0004);
      chk("align_ch1_clk", 32'(dc1), 32'h0038);
      chk("align_ch1_tick", 32'(tk1), 32'h0001);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divided-clock channels.
REQ-002 Parameter CNT_W, default 16: width of divide ratio and period counter.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 cfg_valid  input  1: configuration request valid.
REQ-006 cfg_ready  output  1: configuration accepted when cfg_valid && cfg_ready.
REQ-007 cfg_ch  input  $clog2(NUM_CH): target channel.
REQ-008 cfg_div  input  CNT_W: divide ratio N, legal range 2..2^CNT_W-1.
REQ-009 cfg_en  input  1: 1 = run channel at N, 0 = stop channel.
REQ-010 cfg_err  output  1: one-cycle pulse on an illegal ratio request.
REQ-011 div_clk  output  NUM_CH: registered divided clocks, one bit per channel.
REQ-012 tick  output  NUM_CH: one-cycle pulse in the last clk cycle of each channel period.
REQ-013 busy  output  NUM_CH: channel has an update pending.

Function
REQ-014 Each channel SHALL have states OFF, RUN and PEND (running with a queued update).
REQ-015 In RUN/PEND, counter cnt SHALL count 0..N-1 and wrap to 0; div_clk=1 while cnt < N/2 (integer division), else 0.
REQ-016 N=2 SHALL give 1 high/1 low; N=3 SHALL give 1 high/2 low; tick=1 exactly when cnt==N-1.
REQ-017 cfg_ready SHALL equal !busy[cfg_ch], combinationally from cfg_ch.
REQ-018 An accepted request with cfg_en=1 and cfg_div<2 SHALL be dropped, pulse cfg_err the next cycle, and leave the channel state unchanged.
REQ-019 An accepted legal request to an OFF channel SHALL apply on the next cycle: with cfg_en=1, cnt=0 and div_clk=1 on that cycle; with cfg_en=0, no change.
REQ-020 An accepted legal request to a RUN channel SHALL move it to PEND; the update applies in the cycle after the next tick, so no period is ever truncated.
REQ-021 When an update is applied with cfg_en=1, the next period SHALL use the new N starting at cnt=0.
REQ-022 When an update is applied with cfg_en=0, the channel SHALL enter OFF with div_clk=0 and cnt held at 0.
REQ-023 A request accepted in the same cycle as that channel's tick SHALL apply at the following tick, not the current one.
REQ-024 Requests to different channels SHALL be independent; one request at most is accepted per cycle.

Reset
REQ-025 While rst_n=0: all channels OFF, cnt=0, stored N=2, div_clk=0, tick=0, busy=0, cfg_err=0; cfg_ready SHALL be 1 after the first reset edge.
REQ-026 Reset asserted mid-period or with updates pending SHALL discard them; no tick is emitted on the reset cycle.

Configuration
REQ-027 Macro CLK_DIV_CTRL_ALIGN_EN SHALL control the phase-align feature.
REQ-028 With CLK_DIV_CTRL_ALIGN_EN defined, a 1-bit input align is present. align=1 SHALL restart every RUN/PEND channel at cnt=0 on the next cycle, apply all pending updates at the same time, and suppress tick in that cycle.
REQ-029 Without CLK_DIV_CTRL_ALIGN_EN, the align port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package clk_div_ctrl_pkg SHALL hold the channel state enum (OFF/RUN/PEND), the MIN_DIV=2 constant and the default NUM_CH/CNT_W values.
REQ-031 Per-channel counter, FSM and pending register SHALL be a sub-module clk_div_ch, instantiated NUM_CH times.
REQ-032 clk_div_ctrl SHALL contain only the request decode, cfg_ready/cfg_err logic and align fan-out.

Verification
REQ-033 Reset, then ch0 set to div=4, en=1 -> div_clk[0] runs 2 high/2 low; tick[0] every 4th cycle; other channels stay 0.
REQ-034 ch1 set to div=5 -> 2 high/3 low. Then ch1 set to div=2 mid-period -> busy[1]=1 and cfg_ready=0 for ch1 until the period ends; next period is 1 high/1 low.
REQ-035 ch2 set to div=1 -> cfg_err pulses once; busy[2]=0; div_clk[2] unchanged.
REQ-036 Request ch0 en=0 in the cycle tick[0]=1 -> the current period and one more full period complete, then div_clk[0]=0 and the channel is OFF.
REQ-037 rst_n=0 with ch0 and ch1 running and ch1 pending -> the next cycle has all outputs 0, busy=0 and cfg_ready=1.
REQ-038 With CLK_DIV_CTRL_ALIGN_EN: ch0 at div=4 and ch1 at div=6, one-cycle align pulse -> both restart at cnt=0 together, and no tick occurs in the restart cycle.
